// File: rtl/pulse_detector_pkg.sv
// Shared definitions for the pulse detector: FSM encodings, default sizes and strobe bundle.
// Pulse generator benches reuse the same encodings and defaults.
package pulse_detector_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_OVERRUN = 2'd2;

    localparam int DEF_WIDTH_BITS = 8;
    localparam int DEF_COUNT_BITS = 8;
    localparam int DEF_MIN_WIDTH  = 2;
    localparam int DEF_MAX_WIDTH  = 200;

    typedef struct packed {
        logic valid;
        logic glitch;
        logic overrun;
    } strobe_t;

endpackage

// File: rtl/pulse_detector_if.sv
// Pulse line in, measurement results out; the stimulus side is the master.
interface pulse_detector_if import pulse_detector_pkg::*; #(
    parameter int WIDTH_BITS = DEF_WIDTH_BITS,
    parameter int COUNT_BITS = DEF_COUNT_BITS
);
    logic                  signal_in;
    logic                  clear;
    logic [WIDTH_BITS-1:0] width;
    logic                  valid;
    logic                  glitch;
    logic                  overrun;
    logic                  busy;
    logic [COUNT_BITS-1:0] pulse_count;

    modport master (
        output signal_in, clear,
        input  width, valid, glitch, overrun, busy, pulse_count
    );

    modport slave (
        input  signal_in, clear,
        output width, valid, glitch, overrun, busy, pulse_count
    );
endinterface

// File: rtl/pulse_detector_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous line, async active-high reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic s1_q, s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/pulse_detector.sv
// Measures high pulses on an asynchronous line in clock cycles; reports accepted
// pulses with width and running count, and flags glitches and overruns.
module pulse_detector import pulse_detector_pkg::*; #(
    parameter int WIDTH_BITS = DEF_WIDTH_BITS,
    parameter int COUNT_BITS = DEF_COUNT_BITS,
    parameter int MIN_WIDTH  = DEF_MIN_WIDTH,
    parameter int MAX_WIDTH  = DEF_MAX_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    pulse_detector_if.slave pd
);
    logic                  s2, s3_q, rise, fall;
    logic [1:0]            state_q, state_d;
    logic [WIDTH_BITS-1:0] cnt_q, cnt_d, width_q, width_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    strobe_t               stb_q, stb_d;

    sync_2ff u_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (pd.signal_in),
        .q_o   (s2)
    );

    assign rise = s2 & ~s3_q;
    assign fall = ~s2 & s3_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        count_d = count_q;
        stb_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = WIDTH_BITS'(1);
                end
            end
            ST_MEASURE: begin
                if (s2) begin
                    cnt_d = cnt_q + 1'b1;
                    // Stop counting at MAX_WIDTH so the counter can never wrap.
                    if (cnt_d == WIDTH_BITS'(MAX_WIDTH)) begin
                        stb_d.overrun = 1'b1;
                        state_d       = ST_OVERRUN;
                    end
                end else if (fall) begin
                    state_d = ST_IDLE;
                    if (cnt_q >= WIDTH_BITS'(MIN_WIDTH)) begin
                        width_d     = cnt_q;
                        count_d     = count_q + 1'b1;
                        stb_d.valid = 1'b1;
                    end else begin
                        stb_d.glitch = 1'b1;
                    end
                end
            end
            ST_OVERRUN: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (pd.clear) count_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s3_q    <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            count_q <= '0;
            stb_q   <= '0;
        end else begin
            s3_q    <= s2;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            count_q <= count_d;
            stb_q   <= stb_d;
        end
    end

    assign pd.width       = width_q;
    assign pd.valid       = stb_q.valid;
    assign pd.glitch      = stb_q.glitch;
    assign pd.overrun     = stb_q.overrun;
    assign pd.busy        = (state_q != ST_IDLE);
    assign pd.pulse_count = count_q;
endmodule

// File: tb/tb_pulse_detector.sv
// Directed bench for pulse_detector: table of single pulses plus multi-cycle corner sequences.
module tb_pulse_detector;
    logic clock, reset;
    int   nchk, nfail;
    int   n_valid, n_glitch, n_ovr, n_multi;

    pulse_detector_if #(.WIDTH_BITS(8), .COUNT_BITS(8)) pd ();

    pulse_detector #(
        .WIDTH_BITS(8), .COUNT_BITS(8), .MIN_WIDTH(2), .MAX_WIDTH(200)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pd    (pd)
    );

    initial begin
        clock = 1'b0;
        forever #12 clock = ~clock;
    end

    always @(negedge clock) begin
        if (pd.valid)   n_valid  <= n_valid + 1;
        if (pd.glitch)  n_glitch <= n_glitch + 1;
        if (pd.overrun) n_ovr    <= n_ovr + 1;
        if ((int'(pd.valid) + int'(pd.glitch) + int'(pd.overrun)) > 1) n_multi <= n_multi + 1;
    end

    typedef struct {
        int hi;
        int dv, dg, dov;
        int w, c;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        @(negedge clock) pd.signal_in = 1'b1;
        repeat (hi) @(negedge clock);
        pd.signal_in = 1'b0;
        repeat (lo) @(negedge clock);
        #1;
    endtask

    initial begin
        int v0, g0, o0;
        nchk = 0; nfail = 0;
        n_valid = 0; n_glitch = 0; n_ovr = 0; n_multi = 0;
        tbl[0] = '{5,   1, 0, 0, 5,   1};
        tbl[1] = '{1,   0, 1, 0, 5,   1};
        tbl[2] = '{2,   1, 0, 0, 2,   2};
        tbl[3] = '{199, 1, 0, 0, 199, 3};
        tbl[4] = '{200, 0, 0, 1, 199, 3};
        tbl[5] = '{300, 0, 0, 1, 199, 3};
        tbl[6] = '{3,   1, 0, 0, 3,   4};

        reset = 1'b1; pd.signal_in = 1'b0; pd.clear = 1'b0;
        #20;
        chk("rst width", pd.width, 0);
        chk("rst valid", pd.valid, 0);
        chk("rst glitch", pd.glitch, 0);
        chk("rst overrun", pd.overrun, 0);
        chk("rst busy", pd.busy, 0);
        chk("rst count", pd.pulse_count, 0);
        #10 reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            v0 = n_valid; g0 = n_glitch; o0 = n_ovr;
            pulse(tbl[i].hi, 6);
            chk($sformatf("t%0d valid", i), n_valid - v0, tbl[i].dv);
            chk($sformatf("t%0d glitch", i), n_glitch - g0, tbl[i].dg);
            chk($sformatf("t%0d overrun", i), n_ovr - o0, tbl[i].dov);
            chk($sformatf("t%0d width", i), pd.width, tbl[i].w);
            chk($sformatf("t%0d count", i), pd.pulse_count, tbl[i].c);
            chk($sformatf("t%0d busy", i), pd.busy, 0);
        end

        // Long pulse: overrun exactly at the 200th sample, busy until the line falls.
        v0 = n_valid; o0 = n_ovr;
        @(negedge clock) pd.signal_in = 1'b1;
        repeat (201) @(negedge clock);
        #1 chk("ovr early", pd.overrun, 0);
        @(negedge clock); #1 chk("ovr at 200", pd.overrun, 1);
        @(negedge clock); #1 chk("ovr one cycle", pd.overrun, 0);
        repeat (47) @(negedge clock);
        #1 chk("ovr busy", pd.busy, 1);
        pd.signal_in = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        chk("ovr busy end", pd.busy, 0);
        chk("ovr no valid", n_valid - v0, 0);
        chk("ovr strobes", n_ovr - o0, 1);
        chk("ovr count", pd.pulse_count, 4);

        // Two 3-cycle pulses separated by a single low cycle.
        v0 = n_valid;
        @(negedge clock) pd.signal_in = 1'b1;
        repeat (3) @(negedge clock);
        pd.signal_in = 1'b0;
        @(negedge clock) pd.signal_in = 1'b1;
        repeat (3) @(negedge clock);
        pd.signal_in = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        chk("gap valids", n_valid - v0, 2);
        chk("gap width", pd.width, 3);
        chk("gap count", pd.pulse_count, 6);

        // Reset in the middle of a pulse (cnt=4).
        v0 = n_valid; g0 = n_glitch; o0 = n_ovr;
        @(negedge clock) pd.signal_in = 1'b1;
        repeat (6) @(negedge clock);
        #1 chk("mid busy", pd.busy, 1);
        reset = 1'b1; pd.signal_in = 1'b0;
        #2;
        chk("mid rst width", pd.width, 0);
        chk("mid rst count", pd.pulse_count, 0);
        chk("mid rst busy", pd.busy, 0);
        @(negedge clock) reset = 1'b0;
        repeat (6) @(negedge clock);
        #1 chk("mid no strobe", (n_valid - v0) + (n_glitch - g0) + (n_ovr - o0), 0);
        pulse(4, 6);
        chk("post rst valid", n_valid - v0, 1);
        chk("post rst width", pd.width, 4);
        chk("post rst count", pd.pulse_count, 1);

        // Clear on the same edge as valid.
        @(negedge clock) pd.signal_in = 1'b1;
        repeat (3) @(negedge clock);
        pd.signal_in = 1'b0;
        repeat (2) @(negedge clock);
        pd.clear = 1'b1;
        @(negedge clock);
        #1;
        chk("clr valid", pd.valid, 1);
        chk("clr count", pd.pulse_count, 0);
        chk("clr width", pd.width, 3);
        pd.clear = 1'b0;

        // Count wraps after 256 accepted pulses.
        v0 = n_valid;
        for (int k = 0; k < 255; k++) pulse(2, 2);
        repeat (4) @(negedge clock);
        #1 chk("wrap 255", pd.pulse_count, 255);
        pulse(2, 6);
        chk("wrap 0", pd.pulse_count, 0);
        chk("wrap valids", n_valid - v0, 256);
        chk("wrap width", pd.width, 2);

        chk("strobe exclusive", n_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
